dig_scan: RTL and testbench
===========================

Name: dig_scan

Overview:
- Time-multiplexed scan controller that shares one 4-bit seven-segment decoder across NDIG digit positions.
- Each scan slot presents one nibble on x0..x3 (x0 = MSB) to the decoder and asserts that digit's active-low select line.
- Display values are loaded through a tear-free handshake: a new value is committed only at a frame boundary.
- Sits between the register/IO logic that produces display values and the board-level segment/digit pins.

Parameters:
- NDIG, 4, number of multiplexed digits; legal range 1..8. Value width is 4*NDIG.
- DIV, 50000, clock cycles per digit slot; legal range 2..65535. Prescaler is 16 bits.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  scan enable; 0 freezes the scan and blanks all digits
- load  in  1  single-cycle request to capture value
- value  in  4*NDIG  display value; nibble i drives digit i (nibble 0 = bits 3:0)
- blank  in  NDIG  per-digit blank mask; 1 keeps that digit dark
- x0  out  1  decoder input bit 3 (MSB)
- x1  out  1  decoder input bit 2
- x2  out  1  decoder input bit 1
- x3  out  1  decoder input bit 0
- sel  out  NDIG  digit selects, active-low, at most one low at a time
- busy  out  1  a loaded value is pending commit
- frame  out  1  one-cycle pulse at the end of each full scan frame

Behaviour:
- Reset (async, active-high): prescaler cnt=0, ptr=0, shadow=0, pend=0, pend_val=0. Outputs: x0..x3=0, sel=all 1s, busy=0, frame=0.
- Prescaler:
  - When en=1: cnt increments each clk; tick=1 when cnt==DIV-1, and cnt wraps to 0 on that cycle.
  - When en=0: cnt holds.
- Digit pointer:
  - ptr advances on tick; it wraps NDIG-1 -> 0. With NDIG=1, ptr stays 0.
  - frame_end = tick && ptr==NDIG-1.
- Load handshake (pending register + shadow):
  - load=1 captures value into pend_val and sets pend=1. busy = pend, registered.
  - A load while pend=1 overwrites pend_val; the last load wins.
  - At frame_end with pend=1: shadow <= pend_val; pend <= 0.
  - load and frame_end in the same cycle: shadow <= the old pend_val (if pend=1); pend_val <= value; pend stays/becomes 1.
  - load is accepted regardless of en. While en=0 there is no frame_end, so busy holds until scanning resumes.
- Outputs (registered, 1-cycle latency from ptr):
  - {x0,x1,x2,x3} <= shadow nibble[ptr].
  - sel <= ~(1<<ptr), except sel <= all 1s when en=0 or blank[ptr]=1.
  - When blanked, x0..x3 still present the nibble; only sel is suppressed.
- frame pulse:
  - frame <= frame_end, registered, so it is high for exactly one clk.
  - It is coincident with the first output cycle showing the committed shadow.
- en deassert mid-slot: cnt and ptr hold; sel goes all 1s on the next clk. On reassert, scanning resumes from the held cnt/ptr with no restart.
- Reset mid-frame: all state clears immediately; pending loads are discarded.

Decomposition:
- Shared package: SEL_OFF (all-ones select constant) and the DIV/NDIG legal-range bounds.
- One sub-module, scan_prescaler: parameter DIV; inputs clk, reset, en; outputs tick and cnt.
- Pointer, load handshake and output registers stay in dig_scan.

Test Plan (DIV=4, NDIG=4 unless stated):
- Reset, en=1, load value=16'h1234 at cycle 2 -> busy=1 until the first frame_end (cycle 15). frame pulses on cycle 16. From cycle 16, slot outputs are x=4 with sel=1110, then x=3/1101, x=2/1011, x=1/0111, 4 cycles each.
- Load 16'hAAAA then 16'h5555 within one frame -> only 5555 is displayed after the boundary; AAAA never appears on x.
- load coincident with frame_end: pending h1111 commits, new h2222 stays pending -> busy=1 through the next frame; h2222 is displayed the frame after.
- blank=4'b0101 -> sel never goes low in slots 0 and 2; slots 1 and 3 show sel=1101 and 0111.
- en=0 for 10 cycles mid-slot 2 -> sel=1111 from the next clk; cnt and ptr frozen. After re-enable, slot 2 completes its remaining cycles.
- NDIG=1, DIV=2: frame pulses every 2 cycles and sel is constantly 0 when enabled. Assert reset mid-run -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/dig_scan_pkg.sv
// Shared constants and types for the dig_scan multiplexed display controller.
package dig_scan_pkg;

    // Legal parameter ranges for the scan controller.
    localparam int NDIG_MIN = 1;
    localparam int NDIG_MAX = 8;
    localparam int DIV_MIN  = 2;
    localparam int DIV_MAX  = 65535;

    // Prescaler counter width; DIV_MAX fits exactly.
    localparam int CNT_W = 16;

    // All digit selects inactive (active-low); sliced to NDIG by users.
    localparam logic [NDIG_MAX-1:0] SEL_OFF = '1;

    typedef logic [3:0] nibble_t;

    // Width of the digit pointer; a single digit still needs one bit.
    function automatic int ptrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot prescaler: counts clk cycles while enabled and flags the last cycle of each slot.
module scan_prescaler
    import dig_scan_pkg::*;
#(
    parameter int DIV = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    output logic             tick,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    assign tick = en && (cnt == CNT_LAST);

    // Count up while scanning, wrap at the end of a slot, hold when disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 16'd1;
        end
    end

endmodule

// File: rtl/dig_scan.sv
// Time-multiplexed seven-segment scan controller with tear-free value loading.
module dig_scan
    import dig_scan_pkg::*;
#(
    parameter int NDIG = 4,
    parameter int DIV  = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              load,
    input  logic [4*NDIG-1:0] value,
    input  logic [NDIG-1:0]   blank,
    output logic              x0,
    output logic              x1,
    output logic              x2,
    output logic              x3,
    output logic [NDIG-1:0]   sel,
    output logic              busy,
    output logic              frame
);

    localparam int              PW          = ptrWidth(NDIG);
    localparam logic [PW-1:0]   PTR_LAST    = PW'(NDIG - 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
    localparam logic [NDIG-1:0] SEL_ALL_OFF = SEL_OFF[NDIG-1:0];

    logic              w_tick;
    logic [CNT_W-1:0]  w_cnt;
    logic              w_slotLast;
    logic              w_frameEnd;
    logic [PW-1:0]     w_ptrNext;
    logic [4*NDIG-1:0] w_shadowNext;
    nibble_t           w_nibbleNext;
    logic [NDIG-1:0]   w_selNext;

    logic [PW-1:0]     r_ptr;
    logic [4*NDIG-1:0] r_shadow;
    logic [4*NDIG-1:0] r_pendVal;
    logic              r_pend;
    nibble_t           r_x;
    logic [NDIG-1:0]   r_sel;
    logic              r_frame;

    scan_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .tick  (w_tick),
        .cnt   (w_cnt)
    );

    // The tick only fires on the last count; checking both keeps the frame edge tied to the counter state.
    assign w_slotLast = w_tick && (w_cnt == CNT_LAST);
    assign w_frameEnd = w_slotLast && (r_ptr == PTR_LAST);

    // Next pointer and next shadow, so outputs line up with the state they describe.
    always_comb begin
        w_ptrNext = r_ptr;
        if (w_slotLast) begin
            w_ptrNext = (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
        end
        w_shadowNext = (w_frameEnd && r_pend) ? r_pendVal : r_shadow;
    end

    // Nibble and select pattern for the digit that will be shown next cycle.
    always_comb begin
        w_nibbleNext = w_shadowNext[4*int'(w_ptrNext) +: 4];
        w_selNext    = SEL_ALL_OFF;
        if (en && !blank[w_ptrNext]) begin
            w_selNext[w_ptrNext] = 1'b0;
        end
    end

    // Digit pointer and displayed (shadow) value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr    <= '0;
            r_shadow <= '0;
        end else begin
            r_ptr    <= w_ptrNext;
            r_shadow <= w_shadowNext;
        end
    end

    // Pending load: last load wins, cleared only when committed at a frame boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend    <= 1'b0;
            r_pendVal <= '0;
        end else if (load) begin
            r_pend    <= 1'b1;
            r_pendVal <= value;
        end else if (w_frameEnd) begin
            r_pend    <= 1'b0;
        end
    end

    // Registered pin drivers; frame pulses alongside the first cycle of the new shadow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x     <= '0;
            r_sel   <= SEL_ALL_OFF;
            r_frame <= 1'b0;
        end else begin
            r_x     <= w_nibbleNext;
            r_sel   <= w_selNext;
            r_frame <= w_frameEnd;
        end
    end

    assign {x0, x1, x2, x3} = r_x;
    assign sel   = r_sel;
    assign busy  = r_pend;
    assign frame = r_frame;

endmodule

// File: tb/tb_dig_scan.sv
// Self-checking bench for dig_scan: scoreboard model plus directed corner sequences.
module tb_dig_scan;

    localparam int DIV_T  = 4;
    localparam int NDIG_T = 4;

    typedef struct {
        logic [3:0] x;
        logic [3:0] sel;
        logic       busy;
        logic       frame;
    } exp_t;

    typedef struct {
        int         cyc;
        logic       ld;
        logic [3:0] x;
        logic [3:0] sel;
        logic       busy;
        logic       frame;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        en;
    logic        load;
    logic [15:0] value;
    logic [3:0]  blank;
    logic        x0, x1, x2, x3;
    logic [3:0]  sel;
    logic        busy;
    logic        frame;

    logic        rst1;
    logic        en1;
    logic        load1;
    logic [3:0]  val1;
    logic [0:0]  blank1;
    logic        d1X0, d1X1, d1X2, d1X3;
    logic [0:0]  d1Sel;
    logic        d1Busy;
    logic        d1Frame;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    exp_t sbQ[$];

    int          mCnt;
    int          mPtr;
    logic [15:0] mShadow;
    logic [15:0] mPendVal;
    bit          mPend;

    vec_t vecs[13];

    dig_scan #(
        .NDIG (NDIG_T),
        .DIV  (DIV_T)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .load  (load),
        .value (value),
        .blank (blank),
        .x0    (x0),
        .x1    (x1),
        .x2    (x2),
        .x3    (x3),
        .sel   (sel),
        .busy  (busy),
        .frame (frame)
    );

    dig_scan #(
        .NDIG (1),
        .DIV  (2)
    ) dut1 (
        .clk   (clk),
        .reset (rst1),
        .en    (en1),
        .load  (load1),
        .value (val1),
        .blank (blank1),
        .x0    (d1X0),
        .x1    (d1X1),
        .x2    (d1X2),
        .x3    (d1X3),
        .sel   (d1Sel),
        .busy  (d1Busy),
        .frame (d1Frame)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop if anything stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [3:0] curX();
        return {x0, x1, x2, x3};
    endfunction

    function automatic logic [3:0] curX1();
        return {d1X0, d1X1, d1X2, d1X3};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mCnt     = 0;
        mPtr     = 0;
        mShadow  = '0;
        mPendVal = '0;
        mPend    = 1'b0;
        sbQ.delete();
    endtask

    // Predict the next outputs from the current inputs, queue them, and clock once.
    task automatic applyStimulus();
        bit          tick;
        bit          fe;
        int          nPtr;
        logic [15:0] nShadow;
        exp_t        e;
        tick    = en && (mCnt == DIV_T - 1);
        fe      = tick && (mPtr == NDIG_T - 1);
        nPtr    = tick ? (mPtr + 1) % NDIG_T : mPtr;
        nShadow = (fe && mPend) ? mPendVal : mShadow;
        e.x     = nShadow[nPtr*4 +: 4];
        e.sel   = 4'hF;
        if (en && !blank[nPtr]) e.sel[nPtr] = 1'b0;
        e.frame = fe;
        if (load) begin
            mPendVal = value;
            mPend    = 1'b1;
        end else if (fe) begin
            mPend = 1'b0;
        end
        e.busy = mPend;
        if (en) mCnt = tick ? 0 : mCnt + 1;
        mPtr    = nPtr;
        mShadow = nShadow;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue expected an entry at cycle %0d", cycle);
            return;
        end
        e = sbQ.pop_front();
        check($sformatf("cycle%0d", cycle),
              32'({curX(), sel, busy, frame}),
              32'({e.x, e.sel, e.busy, e.frame}));
        cycle++;
    endtask

    task automatic stepMain();
        applyStimulus();
        checkOutput();
    endtask

    task automatic stepD1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int sawA, fiveCnt, oneCnt, badSel, seen1, seen3, offCnt;

        //                cyc ld  x     sel      busy  frame
        vecs[0]  = '{ 0, 0, 4'h0, 4'b1110, 1'b0, 1'b0};
        vecs[1]  = '{ 2, 1, 4'h0, 4'b1110, 1'b1, 1'b0};
        vecs[2]  = '{ 3, 0, 4'h0, 4'b1101, 1'b1, 1'b0};
        vecs[3]  = '{ 7, 0, 4'h0, 4'b1011, 1'b1, 1'b0};
        vecs[4]  = '{11, 0, 4'h0, 4'b0111, 1'b1, 1'b0};
        vecs[5]  = '{14, 0, 4'h0, 4'b0111, 1'b1, 1'b0};
        vecs[6]  = '{15, 0, 4'h4, 4'b1110, 1'b0, 1'b1};
        vecs[7]  = '{16, 0, 4'h4, 4'b1110, 1'b0, 1'b0};
        vecs[8]  = '{18, 0, 4'h4, 4'b1110, 1'b0, 1'b0};
        vecs[9]  = '{19, 0, 4'h3, 4'b1101, 1'b0, 1'b0};
        vecs[10] = '{23, 0, 4'h2, 4'b1011, 1'b0, 1'b0};
        vecs[11] = '{27, 0, 4'h1, 4'b0111, 1'b0, 1'b0};
        vecs[12] = '{31, 0, 4'h4, 4'b1110, 1'b0, 1'b1};

        reset  = 1'b0;
        en     = 1'b0;
        load   = 1'b0;
        value  = '0;
        blank  = '0;
        rst1   = 1'b0;
        en1    = 1'b0;
        load1  = 1'b0;
        val1   = '0;
        blank1 = '0;
        #2;
        reset = 1'b1;
        rst1  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("resetX",     32'(curX()), 32'h0);
        check("resetSel",   32'(sel),    32'hF);
        check("resetBusy",  32'(busy),   32'h0);
        check("resetFrame", 32'(frame),  32'h0);

        // Table: load 1234 at cycle 2, committed at the first frame boundary.
        modelReset();
        reset = 1'b0;
        en    = 1'b1;
        value = 16'h1234;
        for (int c = 0; c < 32; c++) begin
            load = 1'b0;
            foreach (vecs[i]) if (vecs[i].cyc == c) load = vecs[i].ld;
            stepMain();
            foreach (vecs[i]) begin
                if (vecs[i].cyc == c) begin
                    check($sformatf("vec%0d", c),
                          32'({curX(), sel, busy, frame}),
                          32'({vecs[i].x, vecs[i].sel, vecs[i].busy, vecs[i].frame}));
                end
            end
        end

        // Two loads in one frame: only the last one is ever shown.
        sawA    = 0;
        fiveCnt = 0;
        for (int f = 0; f < 32; f++) begin
            load = (f == 0) || (f == 5);
            if (f == 0) value = 16'hAAAA;
            if (f == 5) value = 16'h5555;
            stepMain();
            if (f == 5) check("busyAfter5555", 32'(busy), 32'h1);
            if (curX() == 4'hA) sawA++;
            if (f >= 16 && curX() == 4'h5) fiveCnt++;
        end
        load = 1'b0;
        check("neverAAAA", 32'(sawA),    32'd0);
        check("fiveCount", 32'(fiveCnt), 32'd16);
        check("busyIdle",  32'(busy),    32'h0);

        // Load landing on frame_end: old pending commits, new one waits a full frame.
        oneCnt = 0;
        for (int f = 0; f < 32; f++) begin
            load = (f == 0) || (f == 15);
            if (f == 0)  value = 16'h1111;
            if (f == 15) value = 16'h2222;
            stepMain();
            if (f == 15) begin
                check("coincBusy",  32'(busy),   32'h1);
                check("coincFrame", 32'(frame),  32'h1);
                check("coincX",     32'(curX()), 32'h1);
            end
            if (f >= 16 && f <= 30 && curX() == 4'h1) oneCnt++;
            if (f == 30) check("busyThroughFrame", 32'(busy), 32'h1);
            if (f == 31) begin
                check("commit2222Busy", 32'(busy),   32'h0);
                check("commit2222X",    32'(curX()), 32'h2);
            end
        end
        load = 1'b0;
        check("oneCount", 32'(oneCnt), 32'd15);

        // Blank mask 0101: digits 0 and 2 stay dark.
        blank  = 4'b0101;
        badSel = 0;
        seen1  = 0;
        seen3  = 0;
        for (int f = 0; f < 16; f++) begin
            stepMain();
            if (sel[0] == 1'b0 || sel[2] == 1'b0) badSel++;
            if (sel == 4'b1101) seen1++;
            if (sel == 4'b0111) seen3++;
        end
        blank = 4'b0000;
        check("blankedSlots", 32'(badSel), 32'd0);
        check("slot1Shown",   32'(seen1),  32'd4);
        check("slot3Shown",   32'(seen3),  32'd4);

        // Pause mid-slot 2 for 10 cycles, with a load accepted while paused.
        for (int f = 0; f < 9; f++) stepMain();
        en     = 1'b0;
        offCnt = 0;
        for (int f = 0; f < 10; f++) begin
            load  = (f == 0);
            value = 16'h9876;
            stepMain();
            if (sel == 4'hF) offCnt++;
        end
        load = 1'b0;
        check("pauseSelOff", 32'(offCnt),              32'd10);
        check("pausePtr",    32'(dut.r_ptr),           32'd2);
        check("pauseCnt",    32'(dut.u_prescaler.cnt), 32'd1);
        check("pauseBusy",   32'(busy),                32'h1);
        en = 1'b1;
        stepMain();
        check("resume1", 32'(sel), 32'(4'b1011));
        stepMain();
        check("resume2", 32'(sel), 32'(4'b1011));
        stepMain();
        check("resume3", 32'(sel), 32'(4'b0111));
        for (int f = 0; f < 4; f++) stepMain();
        check("resumeFrame", 32'(frame),  32'h1);
        check("resumeX",     32'(curX()), 32'h6);
        check("resumeBusy",  32'(busy),   32'h0);

        // Single digit, DIV=2: frame every other cycle, select always on.
        rst1  = 1'b0;
        en1   = 1'b1;
        load1 = 1'b1;
        val1  = 4'h7;
        for (int k = 0; k < 8; k++) begin
            stepD1();
            load1 = 1'b0;
            check($sformatf("d1Frame%0d", k), 32'(d1Frame), 32'((k % 2) == 1));
            check($sformatf("d1Sel%0d", k),   32'(d1Sel),   32'h0);
            if (k == 0) check("d1BusyLoaded", 32'(d1Busy), 32'h1);
            if (k == 1) check("d1BusyCommit", 32'(d1Busy), 32'h0);
        end
        check("d1X", 32'(curX1()), 32'h7);

        // Asynchronous reset mid-run with a load still pending.
        load1 = 1'b1;
        val1  = 4'h9;
        stepD1();
        load1 = 1'b0;
        check("d1BusyPreReset", 32'(d1Busy), 32'h1);
        #2;
        rst1 = 1'b1;
        #1;
        check("d1AsyncX",     32'(curX1()), 32'h0);
        check("d1AsyncSel",   32'(d1Sel),   32'h1);
        check("d1AsyncBusy",  32'(d1Busy),  32'h0);
        check("d1AsyncFrame", 32'(d1Frame), 32'h0);
        stepD1();
        rst1 = 1'b0;
        stepD1();
        check("d1PendDropped", 32'(d1Busy),  32'h0);
        check("d1ShadowClear", 32'(curX1()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
